// File: rtl/sramc_pkg.sv
// Shared types and defaults for the two-master SRAM arbiter.
// State encodings double as the arb_owner output encoding.
package sramc_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 14;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_MAX_HOLD   = 16;

  localparam logic [1:0] OWNER_IDLE = 2'b00;
  localparam logic [1:0] OWNER_M0   = 2'b01;
  localparam logic [1:0] OWNER_M1   = 2'b10;

  typedef enum logic [1:0] {
    IDLE = OWNER_IDLE,
    OWN0 = OWNER_M0,
    OWN1 = OWNER_M1
  } arb_state_e;

endpackage

// File: rtl/sramc_arb_if.sv
// Bus bundle between the two requesters, the arbiter and the SRAM macro.
// slave = arbiter view, master = requester/array view.
interface sramc_arb_if
  import sramc_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);
  localparam int unsigned BE_W = DATA_WIDTH / 8;

  logic                  m0_req,    m1_req;
  logic                  m0_lock,   m1_lock;
  logic                  m0_we,     m1_we;
  logic [ADDR_WIDTH-1:0] m0_addr,   m1_addr;
  logic [DATA_WIDTH-1:0] m0_wdata,  m1_wdata;
  logic [BE_W-1:0]       m0_be,     m1_be;
  logic                  m0_gnt,    m1_gnt;
  logic [DATA_WIDTH-1:0] m0_rdata,  m1_rdata;
  logic                  m0_rvalid, m1_rvalid;

  logic [BE_W-1:0]       sram_csn;
  logic                  sram_wen;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0] sram_wdata;
  logic [DATA_WIDTH-1:0] sram_rdata;
  logic [1:0]            arb_owner;

  modport slave (
    input  m0_req, m0_lock, m0_we, m0_addr, m0_wdata, m0_be,
    input  m1_req, m1_lock, m1_we, m1_addr, m1_wdata, m1_be,
    output m0_gnt, m0_rdata, m0_rvalid, m1_gnt, m1_rdata, m1_rvalid,
    output sram_csn, sram_wen, sram_addr, sram_wdata, arb_owner,
    input  sram_rdata
  );

  modport master (
    output m0_req, m0_lock, m0_we, m0_addr, m0_wdata, m0_be,
    output m1_req, m1_lock, m1_we, m1_addr, m1_wdata, m1_be,
    input  m0_gnt, m0_rdata, m0_rvalid, m1_gnt, m1_rdata, m1_rvalid,
    input  sram_csn, sram_wen, sram_addr, sram_wdata, arb_owner,
    output sram_rdata
  );

endinterface

// File: rtl/sramc_arb_pick.sv
// Two-way picker: a forced target wins if it requests, a lone request wins,
// and a tie goes to m1 when ptr is set, otherwise to m0.
module sramc_arb_pick (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic [1:0] force_sel,
  output logic [1:0] sel
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sel = 2'b00;
    if ((force_sel & req) != 2'b00) begin
      sel = force_sel & req;
    end else if (req == 2'b11) begin
      sel = ptr ? 2'b10 : 2'b01;
    end else begin
      sel = req;
    end
  end

endmodule

// File: rtl/sramc_arb.sv
// Two-master single-port SRAM arbiter with lock bursts and a MAX_HOLD fairness limit.
// Define SRAMC_ARB_RR_EN for round-robin tie breaking; default is fixed m0 priority.
module sramc_arb
  import sramc_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned MAX_HOLD   = DEF_MAX_HOLD
) (
  input  logic       hclk,
  input  logic       hresetn,
  sramc_arb_if.slave bus
);

  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_e            state, state_next;
  logic [CNT_W-1:0]      hold_cnt, hold_cnt_next;
  logic                  hold_sat;
  logic                  ptr;
  logic [1:0]            req, force_sel, sel_raw, sel;
  logic                  tag_valid, tag_port;
  logic [BE_W-1:0]       csn_mux;
  logic                  wen_mux;
  logic [ADDR_WIDTH-1:0] addr_mux;
  logic [DATA_WIDTH-1:0] wdata_mux;

  assign req      = {bus.m1_req, bus.m0_req};
  assign hold_sat = (hold_cnt == HOLD_LAST);

  // The owner keeps the array while it locks and is under the limit; at the
  // limit the other master is forced in if it is waiting.
  always_comb begin
    force_sel = 2'b00;
    case (state)
      OWN0: begin
        if (hold_sat)                        force_sel = 2'b10;
        else if (bus.m0_req && bus.m0_lock)  force_sel = 2'b01;
      end
      OWN1: begin
        if (hold_sat)                        force_sel = 2'b01;
        else if (bus.m1_req && bus.m1_lock)  force_sel = 2'b10;
      end
      default: force_sel = 2'b00;
    endcase
  end

  sramc_arb_pick u_pick (
    .req       (req),
    .ptr       (ptr),
    .force_sel (force_sel),
    .sel       (sel_raw)
  );

  // Grants are combinational, so they are masked while reset is held.
  assign sel = hresetn ? sel_raw : 2'b00;

  always_comb begin
    state_next    = IDLE;
    hold_cnt_next = '0;
    if (sel[0])      state_next = OWN0;
    else if (sel[1]) state_next = OWN1;
    if (state_next != IDLE && state_next == state) begin
      hold_cnt_next = hold_sat ? hold_cnt : hold_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!hresetn) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      tag_valid <= 1'b0;
      tag_port  <= 1'b0;
    end else begin
      state     <= state_next;
      hold_cnt  <= hold_cnt_next;
      tag_valid <= (sel != 2'b00) && wen_mux;
      tag_port  <= sel[1];
    end
  end

`ifdef SRAMC_ARB_RR_EN
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      ptr <= 1'b0;
    end else if (state_next != IDLE && state_next != state) begin
      ptr <= ~ptr;
    end
  end
`else
  assign ptr = 1'b0;
`endif

  always_comb begin
    csn_mux   = '1;
    wen_mux   = 1'b1;
    addr_mux  = '0;
    wdata_mux = '0;
    if (sel[0]) begin
      csn_mux   = ~bus.m0_be;
      wen_mux   = ~bus.m0_we;
      addr_mux  = bus.m0_addr;
      wdata_mux = bus.m0_wdata;
    end else if (sel[1]) begin
      csn_mux   = ~bus.m1_be;
      wen_mux   = ~bus.m1_we;
      addr_mux  = bus.m1_addr;
      wdata_mux = bus.m1_wdata;
    end
  end

  assign bus.sram_csn   = csn_mux;
  assign bus.sram_wen   = wen_mux;
  assign bus.sram_addr  = addr_mux;
  assign bus.sram_wdata = wdata_mux;
  assign bus.arb_owner  = logic'(state[1]) ? OWNER_M1 : (state[0] ? OWNER_M0 : OWNER_IDLE);

  assign bus.m0_gnt    = sel[0];
  assign bus.m1_gnt    = sel[1];
  assign bus.m0_rvalid = tag_valid && !tag_port;
  assign bus.m1_rvalid = tag_valid && tag_port;
  assign bus.m0_rdata  = bus.m0_rvalid ? bus.sram_rdata : '0;
  assign bus.m1_rdata  = bus.m1_rvalid ? bus.sram_rdata : '0;

endmodule

// File: tb/tb_sramc_arb.sv
// Directed bench for sramc_arb with a behavioural byte-lane SRAM model.
// Builds with or without SRAMC_ARB_RR_EN; the tie-break expectation follows the macro.
module tb_sramc_arb;

  localparam int unsigned AW = 14;
  localparam int unsigned DW = 32;

  logic hclk = 1'b0;
  logic hresetn = 1'b0;
  int   errors = 0;
  int   checks = 0;

  sramc_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sramc_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_HOLD(16)) dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .bus     (bus)
  );

  always #5 hclk = ~hclk;

  function automatic logic [31:0] pat(input logic [13:0] a);
    return {2'b10, a, 2'b01, ~a};
  endfunction

  // SRAM model: lanes written on selected write, read data registered one cycle later.
  logic [31:0] mem [0:16383];
  bit          mem_ready;
  always @(posedge hclk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 16384; i++) mem[i] = pat(14'(i));
      mem_ready = 1'b1;
    end
    if (bus.sram_csn != 4'hF) begin
      if (!bus.sram_wen) begin
        for (int l = 0; l < 4; l++)
          if (!bus.sram_csn[l]) mem[bus.sram_addr][8*l +: 8] = bus.sram_wdata[8*l +: 8];
      end else begin
        bus.sram_rdata <= mem[bus.sram_addr];
      end
    end
  end

  task automatic next_cycle();
    @(posedge hclk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.m0_req = 0; bus.m0_lock = 0; bus.m0_we = 0; bus.m0_addr = '0; bus.m0_wdata = '0; bus.m0_be = '0;
    bus.m1_req = 0; bus.m1_lock = 0; bus.m1_we = 0; bus.m1_addr = '0; bus.m1_wdata = '0; bus.m1_be = '0;
  endtask

  task automatic drive_read(input int m, input logic [13:0] a);
    if (m == 0) begin
      bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = a; bus.m0_be = 4'hF;
    end else begin
      bus.m1_req = 1; bus.m1_we = 0; bus.m1_addr = a; bus.m1_be = 4'hF;
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.m0_req = 1; bus.m1_req = 1; bus.m0_be = 4'hF; bus.m1_be = 4'hF;
    hresetn = 0;
    repeat (2) @(negedge hclk);
    checks++; if ({bus.m1_gnt, bus.m0_gnt} !== 2'b00) begin errors++; $display("FAIL rst_gnt: got %b want 00", {bus.m1_gnt, bus.m0_gnt}); end
    checks++; if ({bus.m1_rvalid, bus.m0_rvalid} !== 2'b00) begin errors++; $display("FAIL rst_rvalid: got %b want 00", {bus.m1_rvalid, bus.m0_rvalid}); end
    checks++; if (bus.sram_csn !== 4'hF) begin errors++; $display("FAIL rst_csn: got %b want 1111", bus.sram_csn); end
    checks++; if (bus.sram_wen !== 1'b1) begin errors++; $display("FAIL rst_wen: got %b want 1", bus.sram_wen); end
    checks++; if (bus.arb_owner !== 2'b00) begin errors++; $display("FAIL rst_owner: got %b want 00", bus.arb_owner); end
    next_cycle();
    clear_inputs();
    hresetn = 1;
    @(negedge hclk);
    checks++; if (bus.arb_owner !== 2'b00) begin errors++; $display("FAIL idle_owner: got %b want 00", bus.arb_owner); end
  endtask

  task automatic test_rr();
    logic [1:0] want;
    next_cycle();
    drive_read(0, 14'h0000); drive_read(1, 14'h0001);
    @(negedge hclk);
    checks++; if ({bus.m1_gnt, bus.m0_gnt} !== 2'b01) begin errors++; $display("FAIL tie_first: got %b want 01", {bus.m1_gnt, bus.m0_gnt}); end
    next_cycle();
    clear_inputs();
    next_cycle();
    drive_read(0, 14'h0000); drive_read(1, 14'h0001);
`ifdef SRAMC_ARB_RR_EN
    want = 2'b10;
`else
    want = 2'b01;
`endif
    @(negedge hclk);
    checks++; if ({bus.m1_gnt, bus.m0_gnt} !== want) begin errors++; $display("FAIL tie_second: got %b want %b", {bus.m1_gnt, bus.m0_gnt}, want); end
    next_cycle();
    clear_inputs();
    @(negedge hclk);
  endtask

  task automatic test_single_read();
    logic [31:0] want;
    want = pat(14'h0010);
    next_cycle();
    drive_read(0, 14'h0010);
    @(negedge hclk);
    checks++; if ({bus.m1_gnt, bus.m0_gnt} !== 2'b01) begin errors++; $display("FAIL rd_gnt: got %b want 01", {bus.m1_gnt, bus.m0_gnt}); end
    checks++; if (bus.sram_csn !== 4'b0000) begin errors++; $display("FAIL rd_csn: got %b want 0000", bus.sram_csn); end
    checks++; if (bus.sram_wen !== 1'b1) begin errors++; $display("FAIL rd_wen: got %b want 1", bus.sram_wen); end
    checks++; if (bus.sram_addr !== 14'h0010) begin errors++; $display("FAIL rd_addr: got %h want 0010", bus.sram_addr); end
    next_cycle();
    clear_inputs();
    @(negedge hclk);
    checks++; if ({bus.m1_rvalid, bus.m0_rvalid} !== 2'b01) begin errors++; $display("FAIL rd_rvalid: got %b want 01", {bus.m1_rvalid, bus.m0_rvalid}); end
    checks++; if (bus.m0_rdata !== want) begin errors++; $display("FAIL rd_data: got %h want %h", bus.m0_rdata, want); end
    checks++; if (bus.m1_rdata !== 32'h0) begin errors++; $display("FAIL rd_other_data: got %h want 0", bus.m1_rdata); end
    checks++; if (bus.arb_owner !== 2'b01) begin errors++; $display("FAIL rd_owner: got %b want 01", bus.arb_owner); end
  endtask

  task automatic test_hold();
    int m0_beats = 0, m1_grants = 0, m1_at = -1, m1_cyc = -1, regrant_at = -1, both = 0, cyc = 0;
    while (m0_beats < 40 && cyc < 100) begin
      next_cycle();
      bus.m0_req = 1; bus.m0_lock = 1; bus.m0_we = 1; bus.m0_be = 4'h0; bus.m0_addr = 14'h0300;
      bus.m1_req = (cyc >= 1) && (m1_grants == 0); bus.m1_we = 1; bus.m1_be = 4'h0; bus.m1_addr = 14'h0301;
      @(negedge hclk);
      if (bus.m0_gnt && bus.m1_gnt) both++;
      if (bus.m1_gnt) begin
        m1_grants++;
        if (m1_at < 0) begin m1_at = m0_beats; m1_cyc = cyc; end
      end
      if (bus.m0_gnt) begin
        if (m1_grants > 0 && regrant_at < 0) regrant_at = cyc;
        m0_beats++;
      end
      cyc++;
    end
    next_cycle();
    clear_inputs();
    @(negedge hclk);
    checks++; if (m0_beats !== 40) begin errors++; $display("FAIL hold_done: got %0d beats want 40", m0_beats); end
    checks++; if (m1_at !== 16) begin errors++; $display("FAIL hold_limit: m1 after %0d m0 beats want 16", m1_at); end
    checks++; if (m1_grants !== 1) begin errors++; $display("FAIL hold_m1_count: got %0d want 1", m1_grants); end
    checks++; if (regrant_at !== m1_cyc + 1) begin errors++; $display("FAIL hold_regrant: got cycle %0d want %0d", regrant_at, m1_cyc + 1); end
    checks++; if (both !== 0) begin errors++; $display("FAIL hold_dual_gnt: got %0d want 0", both); end
  endtask

  task automatic test_write();
    logic [31:0] p, want;
    p    = pat(14'h0123);
    want = {p[31:16], 16'hCCDD};
    next_cycle();
    bus.m1_req = 1; bus.m1_we = 1; bus.m1_addr = 14'h0123; bus.m1_be = 4'b0011; bus.m1_wdata = 32'hAABBCCDD;
    @(negedge hclk);
    checks++; if (bus.m1_gnt !== 1'b1) begin errors++; $display("FAIL wr_gnt: got %b want 1", bus.m1_gnt); end
    checks++; if (bus.sram_csn !== 4'b1100) begin errors++; $display("FAIL wr_csn: got %b want 1100", bus.sram_csn); end
    checks++; if (bus.sram_wen !== 1'b0) begin errors++; $display("FAIL wr_wen: got %b want 0", bus.sram_wen); end
    checks++; if (bus.sram_wdata !== 32'hAABBCCDD) begin errors++; $display("FAIL wr_wdata: got %h want aabbccdd", bus.sram_wdata); end
    next_cycle();
    bus.m1_we = 0; bus.m1_be = 4'hF;
    @(negedge hclk);
    checks++; if (bus.m1_gnt !== 1'b1) begin errors++; $display("FAIL wr_rb_gnt: got %b want 1", bus.m1_gnt); end
    next_cycle();
    clear_inputs();
    @(negedge hclk);
    checks++; if ({bus.m1_rvalid, bus.m0_rvalid} !== 2'b10) begin errors++; $display("FAIL wr_rb_rvalid: got %b want 10", {bus.m1_rvalid, bus.m0_rvalid}); end
    checks++; if (bus.m1_rdata !== want) begin errors++; $display("FAIL wr_rb_data: got %h want %h", bus.m1_rdata, want); end
  endtask

  task automatic test_back_to_back();
    logic [13:0] addrs [4];
    logic [1:0]  want_gnt, want_rv;
    logic [31:0] want_d0, want_d1, p;
    addrs = '{14'h0200, 14'h0201, 14'h0202, 14'h0203};
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      clear_inputs();
      if (k < 4) drive_read(k % 2, addrs[k]);
      want_gnt = (k < 4) ? ((k % 2) ? 2'b10 : 2'b01) : 2'b00;
      want_rv  = (k > 0) ? (((k - 1) % 2) ? 2'b10 : 2'b01) : 2'b00;
      p        = (k > 0) ? pat(addrs[k - 1]) : 32'h0;
      want_d0  = want_rv[0] ? p : 32'h0;
      want_d1  = want_rv[1] ? p : 32'h0;
      @(negedge hclk);
      checks++; if ({bus.m1_gnt, bus.m0_gnt} !== want_gnt) begin errors++; $display("FAIL b2b_gnt[%0d]: got %b want %b", k, {bus.m1_gnt, bus.m0_gnt}, want_gnt); end
      checks++; if ({bus.m1_rvalid, bus.m0_rvalid} !== want_rv) begin errors++; $display("FAIL b2b_rvalid[%0d]: got %b want %b", k, {bus.m1_rvalid, bus.m0_rvalid}, want_rv); end
      checks++; if (bus.m0_rdata !== want_d0) begin errors++; $display("FAIL b2b_m0_data[%0d]: got %h want %h", k, bus.m0_rdata, want_d0); end
      checks++; if (bus.m1_rdata !== want_d1) begin errors++; $display("FAIL b2b_m1_data[%0d]: got %h want %h", k, bus.m1_rdata, want_d1); end
    end
  endtask

  task automatic test_reset_mid_read();
    next_cycle();
    drive_read(0, 14'h0040);
    @(negedge hclk);
    checks++; if (bus.m0_gnt !== 1'b1) begin errors++; $display("FAIL mr_gnt: got %b want 1", bus.m0_gnt); end
    next_cycle();
    hresetn = 0;
    #1;
    checks++; if ({bus.m1_rvalid, bus.m0_rvalid} !== 2'b00) begin errors++; $display("FAIL mr_rvalid: got %b want 00", {bus.m1_rvalid, bus.m0_rvalid}); end
    checks++; if ({bus.m1_gnt, bus.m0_gnt} !== 2'b00) begin errors++; $display("FAIL mr_gnt_rst: got %b want 00", {bus.m1_gnt, bus.m0_gnt}); end
    checks++; if (bus.sram_csn !== 4'hF) begin errors++; $display("FAIL mr_csn: got %b want 1111", bus.sram_csn); end
    checks++; if (bus.sram_wen !== 1'b1) begin errors++; $display("FAIL mr_wen: got %b want 1", bus.sram_wen); end
    checks++; if (bus.arb_owner !== 2'b00) begin errors++; $display("FAIL mr_owner: got %b want 00", bus.arb_owner); end
    next_cycle();
    clear_inputs();
    hresetn = 1;
    @(negedge hclk);
    checks++; if ({bus.m1_rvalid, bus.m0_rvalid} !== 2'b00) begin errors++; $display("FAIL mr_after: got %b want 00", {bus.m1_rvalid, bus.m0_rvalid}); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    test_reset();
    test_rr();
    test_single_read();
    test_hold();
    test_write();
    test_back_to_back();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sramc_arb.md
SRAMC_ARB -- requirements
Module: sramc_arb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 14, SRAM word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, SRAM word width.
REQ-003 SHALL have parameter MAX_HOLD, default 16, maximum consecutive locked grants to one master.
REQ-004 SHALL have port hclk, input, 1, single clock for all logic.
REQ-005 SHALL have port hresetn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port mN_req, input, 1, access request (N=0,1; 0 = AHB slave side, 1 = DMA/BIST side).
REQ-007 SHALL have port mN_lock, input, 1, keep grant for the next beat (burst).
REQ-008 SHALL have port mN_we, input, 1, 1 = write, 0 = read.
REQ-009 SHALL have port mN_addr, input, ADDR_WIDTH, word address.
REQ-010 SHALL have port mN_wdata, input, DATA_WIDTH, write data.
REQ-011 SHALL have port mN_be, input, DATA_WIDTH/8, byte enables.
REQ-012 SHALL have port mN_gnt, output, 1, beat accepted this cycle.
REQ-013 SHALL have port mN_rdata, output, DATA_WIDTH, read data.
REQ-014 SHALL have port mN_rvalid, output, 1, mN_rdata valid.
REQ-015 SHALL have port sram_csn, output, DATA_WIDTH/8, per-byte-lane chip select, active low.
REQ-016 SHALL have port sram_wen, output, 1, write enable, active low.
REQ-017 SHALL have port sram_addr, output, ADDR_WIDTH, array address.
REQ-018 SHALL have port sram_wdata, output, DATA_WIDTH, array write data.
REQ-019 SHALL have port sram_rdata, input, DATA_WIDTH, array read data, valid one cycle after a read select.
REQ-020 SHALL have port arb_owner, output, 2, 00 idle, 01 m0, 10 m1.

Function
REQ-021 SHALL use FSM states IDLE, OWN0, OWN1; the registered state drives arb_owner.
REQ-022 SHALL, in IDLE, move to OWNn for the selected requester; with no request it SHALL stay in IDLE.
REQ-023 SHALL assert mN_gnt combinationally when mN_req is high and the current-cycle arbitration selects N; one beat is accepted per gnt cycle.
REQ-024 SHALL drive the sram_* outputs combinationally from the granted master; sram_csn = ~mN_be on a granted beat, all ones otherwise.
REQ-025 SHALL set sram_wen = ~mN_we when granted, and 1 when idle.
REQ-026 SHALL keep OWNn while mN_req && mN_lock and the hold counter is below MAX_HOLD-1; otherwise it re-arbitrates in the same cycle.
REQ-027 SHALL increment the hold counter on each granted beat of the owner, and clear it on an owner change or IDLE.
REQ-028 SHALL, when the counter saturates and the other master requests, force the grant to the other master on the next beat, even if lock is held.
REQ-029 SHALL register a read-return tag (port, valid) on each granted read; one cycle later it SHALL assert exactly that mN_rvalid with mN_rdata = sram_rdata.
REQ-030 SHALL keep the non-target mN_rdata at zero.
REQ-031 SHALL complete a read return even if ownership changed in the return cycle.
REQ-032 SHALL accept back-to-back reads from alternating masters at full rate, with no bubble.
REQ-033 SHALL give every granted write its data and address in the same cycle; no write data is buffered.

Reset
REQ-034 SHALL, on hresetn low, asynchronously set the state to IDLE, the counter to 0, the rvalid tags to 0, and the RR pointer to m0-preferred.
REQ-035 SHALL hold all outputs inactive (gnt 0, rvalid 0, sram_csn all ones, sram_wen 1, arb_owner 00) during reset.
REQ-036 SHALL drop any in-flight read return when reset is asserted mid-read.

Configuration
REQ-037 SHALL, with SRAMC_ARB_RR_EN defined, break ties on simultaneous requests in IDLE by round robin, with the pointer toggled after each owner change.
REQ-038 SHALL, without SRAMC_ARB_RR_EN, break ties by fixed priority to m0; the MAX_HOLD starvation limit still applies.

Structure
REQ-039 SHALL place the arb_state_e typedef, owner encodings and default parameter constants in package sramc_pkg.
REQ-040 SHALL use one sub-module, sramc_arb_pick: a two-way picker taking the requests, the pointer and the force signal, and returning a one-hot select.

Verification
REQ-041 SHALL check: m0 read only, addr 0x0010 -> m0_gnt at cycle 0, sram_csn=0000 and sram_wen=1, m0_rvalid at cycle 1 with data matching the model.
REQ-042 SHALL check: both request in IDLE with RR_EN -> first grant m0; after m0 releases, both request again -> grant m1.
REQ-043 SHALL check: m0 locked burst of 40 beats with m1 requesting, MAX_HOLD=16 -> m1 granted after beat 16, and m0 re-granted later.
REQ-044 SHALL check: m1 write with be=0011, wdata 0xAABBCCDD -> sram_csn=1100, sram_wen=0; a readback gives 0x????CCDD with only the lower lanes updated.
REQ-045 SHALL check: alternating m0/m1 reads on consecutive cycles -> rvalid routed to the correct port each cycle with no bubbles.
REQ-046 SHALL check: hresetn low in the cycle after a granted read -> no rvalid, and all outputs return to reset values immediately.
